// File: rtl/sar_controller_if.sv
// sar_controller_if: control, DAC and result signals between the SAR engine and its surroundings
interface sar_controller_if;
   logic        enable;
   logic [1:0]  resolution;
   logic        start;
   logic        comp_out;
   logic        sample_en;
   logic        dac_enable;
   logic [15:0] sar_data;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        result_valid;
   modport master (
      input  enable, resolution, start, comp_out,
      output sample_en, dac_enable, sar_data, busy, done, result, result_valid
   );
   modport slave (
      output enable, resolution, start, comp_out,
      input  sample_en, dac_enable, sar_data, busy, done, result, result_valid
   );
endinterface

// File: rtl/sar_controller.sv
// sar_controller: successive-approximation search engine driving a binary-weighted DAC
module sar_controller #(
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 3
) (
   input logic             clk,
   input logic             reset,
   sar_controller_if.master bus
);
   localparam int CMAX = SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0] SETL_LAST = CW'(SETTLE_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, SAMPLE, TRIAL, SETTLE, DECIDE, DONE} state_t;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      k_q, k_d;
   logic [15:0]     sar_data_q, sar_data_d;
   logic [15:0]     result_q, result_d;
   logic            result_valid_q, result_valid_d;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         k_q            <= '0;
         sar_data_q     <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         k_q            <= k_d;
         sar_data_q     <= sar_data_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end
   // Only bits at or below the starting index are ever set, so the unused top bits stay zero.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      k_d            = k_q;
      sar_data_d     = sar_data_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      if (state_q != IDLE && !bus.enable) begin
         state_d    = IDLE;
         sar_data_d = '0;
      end else begin
         case (state_q)
            IDLE: if (bus.start && bus.enable) begin
               state_d        = SAMPLE;
               cnt_d          = '0;
               sar_data_d     = '0;
               result_valid_d = 1'b0;
               k_d            = bus.resolution == 2'b00 ? 4'd11 : bus.resolution == 2'b01 ? 4'd13 : 4'd15;
            end
            SAMPLE: begin
               state_d = cnt_q == SAMP_LAST ? TRIAL : SAMPLE;
               cnt_d   = cnt_q + 1'b1;
            end
            TRIAL: begin
               sar_data_d[k_q] = 1'b1;
               state_d         = SETTLE;
               cnt_d           = '0;
            end
            SETTLE: begin
               state_d = cnt_q == SETL_LAST ? DECIDE : SETTLE;
               cnt_d   = cnt_q + 1'b1;
            end
            DECIDE: begin
               sar_data_d[k_q] = bus.comp_out;
               state_d         = k_q == 4'd0 ? DONE : TRIAL;
               k_d             = k_q - 1'b1;
               // Capture here so result and result_valid rise together with done.
               if (k_q == 4'd0) begin
                  result_d       = sar_data_d;
                  result_valid_d = 1'b1;
               end
            end
            DONE: begin
               state_d    = IDLE;
               sar_data_d = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   assign bus.sample_en    = state_q == SAMPLE;
   assign bus.dac_enable   = state_q inside {SAMPLE, TRIAL, SETTLE, DECIDE};
   assign bus.busy         = state_q != IDLE;
   assign bus.done         = state_q == DONE;
   assign bus.sar_data     = sar_data_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: random and directed conversions against an ideal-comparator reference
module tb_sar_controller;
   localparam int S = 4;
   localparam int ST = 3;
   logic clk = 1'b0;
   logic reset;
   logic [15:0] vin = 16'h0;
   logic [15:0] last_exp = 16'h0;
   int n_tests = 0;
   int n_fail = 0;
   sar_controller_if bus ();
   sar_controller #(.SAMPLE_CYCLES(S), .SETTLE_CYCLES(ST)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   assign bus.comp_out = bus.sar_data <= vin;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_sar"}, bus.sar_data, 0);
      chk({tag, "_dac"}, bus.dac_enable, 0);
      chk({tag, "_smp"}, bus.sample_en, 0);
      chk({tag, "_done"}, bus.done, 0);
   endtask
   task automatic conv(input logic [1:0] res, input logic [15:0] v, input bit extra, input bit chg);
      int n, l, lat, ndone;
      logic hv;
      logic [15:0] exp;
      n = res == 2'b00 ? 12 : res == 2'b01 ? 14 : 16;
      l = 1 + S + n * (ST + 2);
      exp = v & 16'((32'd1 << n) - 1);
      vin = exp;
      bus.resolution = res;
      bus.enable = 1'b1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("accept_busy", bus.busy, 1);
      chk("accept_rv", bus.result_valid, 0);
      lat = 0;
      ndone = 0;
      hv = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         bus.start = extra && (c == 10 || c == 30 || c == 50);
         if (chg && c == 1) bus.resolution = 2'b10;
         @(posedge clk); #1;
         if ((bus.sar_data >> n) != 0) hv = 1'b1;
         if (bus.done) begin
            ndone++;
            if (ndone == 1) begin
               lat = c + 1;
               chk("result", bus.result, exp);
               chk("result_valid", bus.result_valid, 1);
            end
         end
         if (ndone > 0 && !bus.busy) break;
      end
      bus.start = 1'b0;
      chk("latency", lat, l);
      chk("one_done", ndone, 1);
      chk("hi_bits", hv, 0);
      chk("idle_sar", bus.sar_data, 0);
      chk("idle_rv", bus.result_valid, 1);
      last_exp = exp;
   endtask
   initial begin
      logic bad;
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.start = 1'b0;
      bus.resolution = 2'b00;
      #3;
      chk_quiet("rst");
      chk("rst_result", bus.result, 0);
      chk("rst_rv", bus.result_valid, 0);
      @(negedge clk) reset = 1'b0;
      bus.enable = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("idle_nostart", bus.busy, 0);
      // Reset while settling bit 7 of a 12-bit conversion of 0xABC.
      vin = 16'h0ABC;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (S + 4 * (ST + 2) + 1) @(posedge clk);
      #1 chk("pre_rst_sar", bus.sar_data, 16'h0A80);
      #1 reset = 1'b1;
      #1 chk_quiet("midrst");
      chk("midrst_rv", bus.result_valid, 0);
      @(negedge clk) reset = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.busy || bus.done) bad = 1'b1;
      end
      chk("post_rst_idle", bad, 0);
      conv(2'b00, 16'h0ABC, 0, 0);
      conv(2'b10, 16'hFFFF, 0, 0);
      conv(2'b10, 16'h0000, 0, 0);
      conv(2'b01, 16'h2A5F, 1, 0);
      conv(2'b00, 16'h0D2C, 0, 1);
      // Abort during the third trial of a 16-bit conversion.
      vin = 16'h1234;
      bus.resolution = 2'b10;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (S + 2 * (ST + 2)) @(posedge clk);
      #1 chk("pre_abort_busy", bus.busy, 1);
      chk("pre_abort_sar", bus.sar_data, vin & 16'hC000);
      bus.enable = 1'b0;
      @(posedge clk); #1;
      chk_quiet("abort");
      chk("abort_rv", bus.result_valid, 0);
      chk("abort_result", bus.result, last_exp);
      bad = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.busy || bus.done || bus.result_valid) bad = 1'b1;
      end
      chk("abort_quiet", bad, 0);
      bus.enable = 1'b1;
      for (int i = 0; i < 6; i++) conv(2'($urandom_range(0, 3)), 16'($urandom), 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sar_controller.md
Name: sar_controller

Overview:
- Successive-approximation control engine: the initiator end of the SAR data interface that feeds the binary-weighted capacitor DAC array.
- Runs sample phase, then a bit-by-bit trial/settle/decide search. It drives sar_data and dac_enable into the DAC and reads back the analog comparator decision.
- Presents the final N-bit code (N = 12/14/16) with a done pulse and a sticky valid flag to the digital back end.

Parameters:
- SAMPLE_CYCLES, 4, cycles sample_en is held high per conversion (legal >= 1)
- SETTLE_CYCLES, 3, wait cycles after each trial-bit update before the comparator is read (legal >= 1). Must cover the DAC's 2-register pipeline plus comparator delay.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- enable  input  1  block enable; low aborts any conversion
- resolution  input  2  00=12-bit, 01=14-bit, 10=16-bit, 11=16-bit; same encoding as the DAC
- start  input  1  conversion request, sampled in IDLE only
- comp_out  input  1  comparator decision: 1 = analog input >= DAC output (keep bit), 0 = clear bit
- sample_en  output  1  sample/hold switch control
- dac_enable  output  1  DAC enable
- sar_data  output  16  trial code to DAC, LSB-aligned
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle completion pulse
- result  output  16  last completed code, LSB-aligned, upper unused bits zero
- result_valid  output  1  high from done until the next accepted start, abort, or reset

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; all outputs 0.
- States: IDLE, SAMPLE, TRIAL, SETTLE, DECIDE, DONE.
- IDLE:
  - If start=1 and enable=1 at a clock edge, go to SAMPLE.
  - On that edge: latch resolution into N_lat, clear sar_data and result_valid, and set bit index k = N_lat-1.
  - start in any other state is ignored. There is no queuing.
- SAMPLE:
  - sample_en=1, dac_enable=1, sar_data=0 for exactly SAMPLE_CYCLES cycles, then go to TRIAL.
- TRIAL (1 cycle):
  - Set sar_data[k]=1; go to SETTLE.
- SETTLE:
  - Hold sar_data for SETTLE_CYCLES cycles; go to DECIDE.
- DECIDE (1 cycle):
  - Sample comp_out. If comp_out=0, clear sar_data[k].
  - If k=0, go to DONE; otherwise decrement k and go to TRIAL.
- DONE (1 cycle):
  - result <= sar_data; done=1; result_valid <= 1; dac_enable=0.
  - Go to IDLE.
- Output timing:
  - dac_enable=1 in SAMPLE, TRIAL, SETTLE, DECIDE; 0 otherwise.
  - sar_data is cleared to 0 on entry to IDLE.
- Latency:
  - done is high in the cycle following L = 1 + SAMPLE_CYCLES + N*(SETTLE_CYCLES+2) clock edges, counted from the edge that accepts start.
  - With defaults: 12-bit L=65; 14-bit L=75; 16-bit L=85.
  - The earliest next start is accepted in the cycle after done.
- Width rules:
  - sar_data bits [15:N_lat] and result bits [15:N_lat] are always 0.
  - A resolution change mid-conversion has no effect until the next start.
  - Counters are sized with $clog2 of the parameter values; there is no wrap inside a phase.
- Abort:
  - enable=0 in any non-IDLE state goes to IDLE on the next edge.
  - sar_data, sample_en, dac_enable and busy go to 0. No done pulse; result_valid stays 0.
  - result keeps its previous value.
- Comparator handling: comp_out is ignored outside DECIDE. It is assumed synchronous to clk; any synchronizer is external.

Test Plan:
- Reset mid-conversion: assert reset during SETTLE of bit 7 -> all outputs 0 in the same cycle. After release, the block stays IDLE until start.
- 12-bit conversion: resolution=00, start with a comparator model comp_out=(sar_data<=0xABC) -> done 65 cycles after start. result=0x0ABC, result_valid=1, sar_data bits [15:12]=0 throughout.
- 16-bit endpoints: model input 0xFFFF -> result 0xFFFF. Model input 0x0000 -> result 0x0000, with every DECIDE clearing its bit. Both take 85 cycles.
- 14-bit conversion plus start during busy: model input 0x2A5F, extra start pulses mid-conversion -> exactly one done at 75 cycles, result=0x2A5F. The next start, one cycle after done, clears result_valid.
- Abort: drop enable during the 3rd TRIAL -> next cycle IDLE, busy=0, sar_data=0, no done pulse, result holds the prior conversion value, result_valid=0.
- Resolution change mid-run: start with 00, switch to 10 during SAMPLE -> conversion remains 12-bit, latency 65, result < 0x1000.
